mem_arbiter: RTL

Two-master, one-slave bus arbiter that shares the SoC's single memory/peripheral port between the rv32 core's instruction-fetch port and its load/store port. It grants one requester at a time with round-robin tie-breaking and holds the grant until the slave completes. A per-transaction watchdog converts a hung slave into an error response. It sits between the core and the RAM/LED/UART decode in `soc`.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the rv32 fetch/load-store masters, the arbiter and the shared slave port.
// The arbiter uses the master modport; the surrounding SoC (or a bench) uses the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_valid_i;
  logic [ADDR_W-1:0]     i_addr_i;
  logic                  i_ready_o;
  logic                  i_err_o;
  logic                  d_valid_i;
  logic [ADDR_W-1:0]     d_addr_i;
  logic [DATA_W-1:0]     d_wdata_i;
  logic [DATA_W/8-1:0]   d_wstrb_i;
  logic                  d_ready_o;
  logic                  d_err_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  m_valid_o;
  logic [ADDR_W-1:0]     m_addr_o;
  logic [DATA_W-1:0]     m_wdata_o;
  logic [DATA_W/8-1:0]   m_wstrb_o;
  logic                  m_ready_i;
  logic [DATA_W-1:0]     m_rdata_i;

  modport master (
    input  i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
    input  m_ready_i, m_rdata_i,
    output i_ready_o, i_err_o, d_ready_o, d_err_o, rdata_o,
    output m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );

  modport slave (
    output i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
    output m_ready_i, m_rdata_i,
    input  i_ready_o, i_err_o, d_ready_o, d_err_o, rdata_o,
    input  m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) round-robin arbiter onto one slave port, with a
// per-transaction watchdog that turns a hung slave into an error completion.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  state_t           state;
  grant_t           last_grant;
  logic [CNT_W-1:0] wd_cnt;

  logic busy;
  logic timeout;
  logic done;
  logic grant_d;

  // Completion is combinational from the slave; reset suppresses any pulse.
  always_comb begin
    busy    = (state != IDLE) && !rst;
    timeout = busy && !bus.m_ready_i && (TIMEOUT != 0) && (wd_cnt == CNT_LAST);
    done    = (busy && bus.m_ready_i) || timeout;
    grant_d = bus.d_valid_i && (!bus.i_valid_i || last_grant == GNT_I);

    bus.i_ready_o = done && (state == BUSY_I);
    bus.d_ready_o = done && (state == BUSY_D);
    bus.i_err_o   = timeout && (state == BUSY_I);
    bus.d_err_o   = timeout && (state == BUSY_D);
    bus.rdata_o   = (busy && bus.m_ready_i) ? bus.m_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GNT_I;
      wd_cnt        <= '0;
      bus.m_valid_o <= 1'b0;
      bus.m_addr_o  <= '0;
      bus.m_wdata_o <= '0;
      bus.m_wstrb_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid_i || bus.d_valid_i) begin
            wd_cnt        <= '0;
            bus.m_valid_o <= 1'b1;
            if (grant_d) begin
              state         <= BUSY_D;
              last_grant    <= GNT_D;
              bus.m_addr_o  <= bus.d_addr_i;
              bus.m_wdata_o <= bus.d_wdata_i;
              bus.m_wstrb_o <= bus.d_wstrb_i;
            end else begin
              // Fetches are always reads.
              state         <= BUSY_I;
              last_grant    <= GNT_I;
              bus.m_addr_o  <= bus.i_addr_i;
              bus.m_wdata_o <= '0;
              bus.m_wstrb_o <= '0;
            end
          end
        end
        default: begin
          if (done) begin
            state         <= IDLE;
            bus.m_valid_o <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule
